wedge_event_merger: RTL and testbench
=====================================

Name: wedge_event_merger

Overview:
- Parametrised successor to the single-stream wedge fitter front end.
- Accepts NCH independent 23-bit hit/track streams, each with an active-low strobe, and buffers each stream in its own FIFO with hold back-pressure.
- Merges the streams event by event, in channel order, into one output stream that ends with a single combined end-of-event (EE) word.
- Sits between the mezzanine input connectors and the fitter core.

Parameters:
NCH, 4, number of input channels (1..8)
WIDTH, 23, word width; bits [WIDTH-1:WIDTH-2]==2'b11 marks an EE word (e.g. 23'h600000)
DEPTH_LOG2, 6, per-channel FIFO depth = 2**DEPTH_LOG2
OUT_DEPTH_LOG2, 4, output FIFO depth = 2**OUT_DEPTH_LOG2
HOLD_MARGIN, 8, free-entry margin at which hold asserts

Ports:
clock  in  1  single system clock, rising edge
reset  in  1  asynchronous, active-low reset
data_in  in  NCH*WIDTH  channel i occupies [i*WIDTH +: WIDTH]
ds  in  NCH  active-low data strobe per channel
chan_en  in  NCH  1 = channel participates in merge; sampled only in IDLE
hold  out  NCH  per-channel back-pressure, registered
overflow  out  NCH  sticky: a word was dropped on a full channel FIFO
out_re  in  1  output read enable
data_out  out  WIDTH  merged word
out_empty  out  1  output FIFO empty
out_valid  out  1  data_out valid (the cycle after an accepted out_re)

Behaviour:
- Reset values (reset low, asynchronous): all FIFOs empty, FSM=IDLE, hold=0, overflow=0, out_empty=1, out_valid=0, data_out=0.
- Input capture:
  - ds[i]==0 at a clock edge writes data_in slice i into FIFO i.
  - The word is readable by the merger on the next cycle.
  - If FIFO i is full, the word is dropped and overflow[i] is set; overflow[i] stays set until reset.
- hold[i] is registered: it is 1 when the FIFO i count >= 2**DEPTH_LOG2 - HOLD_MARGIN, and 0 otherwise.
- FSM states: IDLE, WAIT, XFER, EMIT_EE.
  - IDLE:
    - Latch chan_en into en_q and set cur = the lowest enabled channel.
    - Go to WAIT when en_q != 0.
    - If en_q == 0, stay in IDLE; the output stays empty.
  - WAIT: go to XFER when FIFO[cur] is non-empty.
  - XFER:
    - Pops one word per cycle from FIFO[cur], only when FIFO[cur] is non-empty and the output FIFO is not full; otherwise it stalls with no pop.
    - A non-EE word is pushed to the output FIFO unchanged.
    - An EE word is not forwarded. Its tag bits [7:0] are captured: the first enabled channel sets ref_tag, and later channels compare against ref_tag and set the sticky flag mism.
    - After an EE word, cur advances to the next enabled channel (then WAIT). If cur was the last enabled channel, the FSM goes to EMIT_EE.
  - EMIT_EE:
    - When the output FIFO is not full, push {2'b11, mism, zero pad, ref_tag}, i.e. bit WIDTH-3 is the tag-mismatch error.
    - Then clear mism and return to IDLE.
- The merger never reorders words within a channel. An empty event (EE only) on a channel contributes no data words.
- Simultaneous events:
  - A write and a pop on the same FIFO in the same cycle are both honoured; the count is unchanged.
  - A write on a full FIFO with a simultaneous pop is accepted (no overflow).
- Output interface:
  - out_re while !out_empty pops the output FIFO.
  - data_out is updated and out_valid=1 on the following cycle; out_valid is 0 otherwise.
  - out_re while out_empty is ignored (out_valid=0, no underflow).
- Reset mid-event: all state is discarded immediately, partial events are lost, and outputs return to their reset values.

Optional Feature:
- Macro: WEDGE_MERGE_ISPY_EN.
- When defined, two extra ports exist:
  - ispy_data out WIDTH+1: {boundary, word}, where boundary=1 on the first word forwarded from each channel and on the merged EE word.
  - ispy_dv out 1: pulses 1 cycle, coincident with each push into the output FIFO.
- When not defined, the ports and spy logic are absent.
- Merge behaviour is identical in both cases.

Decomposition:
- Package wedge_merge_pkg holds:
  - the word typedef (logic [WIDTH-1:0] via parameter default);
  - the EE_MASK constant 2'b11 and the EE bit positions;
  - the mismatch bit index WIDTH-3 and the tag field [7:0];
  - the FSM state enum (IDLE, WAIT, XFER, EMIT_EE).
- One sub-module, wedge_sync_fifo (parametrised width/depth, count output, full/empty). It is instantiated NCH times for the channels and once for the output.

Test Plan:
- NCH=4, all enabled:
  - Stimulus: ch0 sends A0,A1,EE(tag 5); ch1 sends B0,EE(5); ch2 sends EE(5); ch3 sends D0,EE(5), in any interleaving; out_re held 1.
  - Required output: A0,A1,B0,D0,23'h600005, with out_valid high on each of the 5 reads.
- Tag mismatch: ch2 EE tag 6, all others tag 5 -> final word 23'h700005 (bit 20 set).
- chan_en=4'b0101, data on ch0 and ch2 only -> ch1 and ch3 are never read; their FIFOs retain their contents.
- Back-pressure:
  - Stimulus: fill ch0 with 56 words while out_re=0, then keep writing.
  - Required response: hold[0]=1 on the cycle after the 56th write. The 65th word is dropped and sets overflow[0]=1. Other overflow bits stay 0.
- Reset low during XFER -> the next cycle shows out_empty=1, hold=0, overflow=0; a fresh event afterwards merges correctly.
- With WEDGE_MERGE_ISPY_EN: the first test produces 5 ispy_dv pulses, with boundary=1 on A0, B0, D0 and the EE word.

Source files
------------

// File: rtl/wedge_merge_pkg.sv
// Shared types and word-format constants for the wedge event merger.
package wedge_merge_pkg;

    localparam int unsigned WORD_WIDTH = 23;
    typedef logic [WORD_WIDTH-1:0] word_t;

    // Top two bits equal to EE_MASK mark an end-of-event word.
    localparam logic [1:0] EE_MASK = 2'b11;
    localparam int unsigned TAG_W = 8;

    typedef enum logic [1:0] {StIdle, StWait, StXfer, StEmitEe} state_e;

    function automatic int unsigned ee_hi(input int unsigned width);
        return width - 1;
    endfunction

    function automatic int unsigned ee_lo(input int unsigned width);
        return width - 2;
    endfunction

    function automatic int unsigned mism_bit(input int unsigned width);
        return width - 3;
    endfunction

endpackage

// File: rtl/wedge_sync_fifo.sv
// Synchronous FIFO with occupancy count; rd_data shows the head word whenever not empty.
module wedge_sync_fifo #(
    parameter int unsigned Width     = 23,
    parameter int unsigned DepthLog2 = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [Width-1:0]     wr_data,
    input  logic                 rd_en,
    output logic [Width-1:0]     rd_data,
    output logic                 full,
    output logic                 empty,
    output logic [DepthLog2:0]   count
);

    localparam int unsigned Depth = 2 ** DepthLog2;

    logic [Width-1:0]     mem [Depth];
    logic [DepthLog2-1:0] wr_ptr_q, rd_ptr_q;
    logic [DepthLog2:0]   count_q;
    logic                 do_wr, do_rd;

    assign empty = (count_q == '0);
    assign full  = (count_q == (DepthLog2 + 1)'(Depth));
    assign count = count_q;
    assign do_rd = rd_en && !empty;
    // A simultaneous pop frees the slot, so a write on a full FIFO still lands.
    assign do_wr = wr_en && (!full || do_rd);
    assign rd_data = mem[rd_ptr_q];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + {{DepthLog2{1'b0}}, do_wr} - {{DepthLog2{1'b0}}, do_rd};
        end
    end

    always_ff @(posedge clock) begin
        if (do_wr) mem[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/wedge_event_merger.sv
// Merges NCH buffered hit streams event by event into one stream with a combined EE word.
// Optional spy port enabled by defining WEDGE_MERGE_ISPY_EN.
module wedge_event_merger
    import wedge_merge_pkg::*;
#(
    parameter int unsigned NCH            = 4,
    parameter int unsigned WIDTH          = WORD_WIDTH,
    parameter int unsigned DEPTH_LOG2     = 6,
    parameter int unsigned OUT_DEPTH_LOG2 = 4,
    parameter int unsigned HOLD_MARGIN    = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NCH*WIDTH-1:0] data_in,
    input  logic [NCH-1:0]       ds,
    input  logic [NCH-1:0]       chan_en,
    output logic [NCH-1:0]       hold,
    output logic [NCH-1:0]       overflow,
    input  logic                 out_re,
    output logic [WIDTH-1:0]     data_out,
    output logic                 out_empty,
    output logic                 out_valid
`ifdef WEDGE_MERGE_ISPY_EN
    ,
    output logic [WIDTH:0]       ispy_data,
    output logic                 ispy_dv
`endif
);

    localparam int unsigned CurW    = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned EeHi    = ee_hi(WIDTH);
    localparam int unsigned EeLo    = ee_lo(WIDTH);
    localparam int unsigned MismBit = mism_bit(WIDTH);
    localparam logic [DEPTH_LOG2:0] HoldThr = (DEPTH_LOG2 + 1)'(2 ** DEPTH_LOG2 - HOLD_MARGIN);

    state_e            state_q;
    logic [NCH-1:0]    en_q;
    logic [CurW-1:0]   cur_q, first_en, next_en;
    logic              next_found;
    logic [TAG_W-1:0]  ref_tag_q;
    logic              ref_set_q, mism_q;

    logic [WIDTH-1:0]      ch_rdata [NCH];
    logic [DEPTH_LOG2:0]   ch_count [NCH];
    logic [NCH-1:0]        ch_full, ch_empty, ch_pop;

    logic [WIDTH-1:0]        cur_word, ee_word, out_wdata, out_rdata;
    logic [OUT_DEPTH_LOG2:0] out_count;
    logic                    cur_is_ee, pop, out_full, out_push, out_pop;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic                wr_ok;
        logic [DEPTH_LOG2:0] count_next;
        logic                hold_q, overflow_q;

        wedge_sync_fifo #(
            .Width     (WIDTH),
            .DepthLog2 (DEPTH_LOG2)
        ) u_fifo (
            .clock   (clock),
            .reset   (reset),
            .wr_en   (!ds[i]),
            .wr_data (data_in[i*WIDTH +: WIDTH]),
            .rd_en   (ch_pop[i]),
            .rd_data (ch_rdata[i]),
            .full    (ch_full[i]),
            .empty   (ch_empty[i]),
            .count   (ch_count[i])
        );

        assign ch_pop[i]  = pop && (cur_q == CurW'(i));
        assign wr_ok      = !ds[i] && (!ch_full[i] || ch_pop[i]);
        // hold tracks the post-edge occupancy so it lines up with the count it reflects.
        assign count_next = ch_count[i] + {{DEPTH_LOG2{1'b0}}, wr_ok}
                                        - {{DEPTH_LOG2{1'b0}}, ch_pop[i]};
        assign hold[i]     = hold_q;
        assign overflow[i] = overflow_q;

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                hold_q     <= 1'b0;
                overflow_q <= 1'b0;
            end else begin
                hold_q <= (count_next >= HoldThr);
                if (!ds[i] && !wr_ok) overflow_q <= 1'b1;
            end
        end
    end

    always_comb begin
        cur_word  = ch_rdata[cur_q];
        cur_is_ee = (cur_word[EeHi:EeLo] == EE_MASK);
        pop       = (state_q == StXfer) && !ch_empty[cur_q] && !out_full;

        ee_word                = '0;
        ee_word[EeHi:EeLo]     = EE_MASK;
        ee_word[MismBit]       = mism_q;
        ee_word[TAG_W-1:0]     = ref_tag_q;

        out_push  = (pop && !cur_is_ee) || ((state_q == StEmitEe) && !out_full);
        out_wdata = (state_q == StEmitEe) ? ee_word : cur_word;

        first_en = '0;
        for (int i = int'(NCH) - 1; i >= 0; i--) begin
            if (chan_en[i]) first_en = CurW'(i);
        end
        next_en    = cur_q;
        next_found = 1'b0;
        for (int i = int'(NCH) - 1; i >= 0; i--) begin
            if (en_q[i] && (CurW'(i) > cur_q)) begin
                next_en    = CurW'(i);
                next_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            en_q      <= '0;
            cur_q     <= '0;
            ref_tag_q <= '0;
            ref_set_q <= 1'b0;
            mism_q    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    en_q      <= chan_en;
                    cur_q     <= first_en;
                    ref_set_q <= 1'b0;
                    if (chan_en != '0) state_q <= StWait;
                end
                StWait: begin
                    if (!ch_empty[cur_q]) state_q <= StXfer;
                end
                StXfer: begin
                    if (pop && cur_is_ee) begin
                        if (!ref_set_q) begin
                            ref_tag_q <= cur_word[TAG_W-1:0];
                            ref_set_q <= 1'b1;
                        end else if (cur_word[TAG_W-1:0] != ref_tag_q) begin
                            mism_q <= 1'b1;
                        end
                        if (next_found) begin
                            cur_q   <= next_en;
                            state_q <= StWait;
                        end else begin
                            state_q <= StEmitEe;
                        end
                    end
                end
                StEmitEe: begin
                    if (!out_full) begin
                        mism_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    wedge_sync_fifo #(
        .Width     (WIDTH),
        .DepthLog2 (OUT_DEPTH_LOG2)
    ) u_out_fifo (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (out_push),
        .wr_data (out_wdata),
        .rd_en   (out_pop),
        .rd_data (out_rdata),
        .full    (out_full),
        .empty   (out_empty),
        .count   (out_count)
    );

    assign out_pop = out_re && (out_count != '0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            data_out  <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= out_pop;
            if (out_pop) data_out <= out_rdata;
        end
    end

`ifdef WEDGE_MERGE_ISPY_EN
    logic fwd_q;

    // fwd_q: current channel has already forwarded a data word this event.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fwd_q <= 1'b0;
        end else if ((state_q == StIdle) || (pop && cur_is_ee)) begin
            fwd_q <= 1'b0;
        end else if (out_push) begin
            fwd_q <= 1'b1;
        end
    end

    assign ispy_dv   = out_push;
    assign ispy_data = {(state_q == StEmitEe) || !fwd_q, out_wdata};
`endif

endmodule

// File: tb/tb_wedge_event_merger.sv
// Scoreboard bench for wedge_event_merger: directed events, queue of expected merged words.
module tb_wedge_event_merger;
    import wedge_merge_pkg::*;

    localparam int unsigned NCH = 4;
    localparam int unsigned W   = 23;

    logic               clock = 1'b0;
    logic               reset = 1'b0;
    logic [NCH*W-1:0]   data_in;
    logic [NCH-1:0]     ds, chan_en, hold, overflow;
    logic               out_re, out_empty, out_valid;
    logic [W-1:0]       data_out;
`ifdef WEDGE_MERGE_ISPY_EN
    logic [W:0]         ispy_data;
    logic               ispy_dv;
    int                 spy_dv_cnt = 0;
    int                 spy_bnd_cnt = 0;
`endif

    word_t exp_q[$];
    int    n_checks = 0;
    int    n_pass = 0;

    wedge_event_merger #(
        .NCH            (NCH),
        .WIDTH          (W),
        .DEPTH_LOG2     (6),
        .OUT_DEPTH_LOG2 (4),
        .HOLD_MARGIN    (8)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .data_in   (data_in),
        .ds        (ds),
        .chan_en   (chan_en),
        .hold      (hold),
        .overflow  (overflow),
        .out_re    (out_re),
        .data_out  (data_out),
        .out_empty (out_empty),
        .out_valid (out_valid)
`ifdef WEDGE_MERGE_ISPY_EN
        ,
        .ispy_data (ispy_data),
        .ispy_dv   (ispy_dv)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, req);
    endtask

    // Monitor: every out_valid cycle consumes one expected word.
    always @(negedge clock) begin
        if (reset && out_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_word: got %h, required no word", data_out);
            end else begin
                chk("merged_word", 32'(data_out), 32'(exp_q.pop_front()));
            end
        end
`ifdef WEDGE_MERGE_ISPY_EN
        if (ispy_dv) begin
            spy_dv_cnt++;
            if (ispy_data[W]) spy_bnd_cnt++;
        end
`endif
    end

    task automatic put(input int ch, input word_t w);
        @(negedge clock);
        data_in = '0;
        data_in[ch*W +: W] = w;
        ds = '1;
        ds[ch] = 1'b0;
        @(posedge clock);
        #1 ds = '1;
    endtask

    task automatic start_event(input logic [NCH-1:0] en);
        @(negedge clock);
        chan_en = en;
        @(posedge clock);
        #1 chan_en = '0;
    endtask

    task automatic wait_drain(input string name);
        int t = 0;
        while ((exp_q.size() != 0 || !out_empty) && t < 500) begin
            @(negedge clock);
            t++;
        end
        repeat (3) @(negedge clock);
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else begin
            $display("FAIL %s_drain: got %0d words outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
        chk({name, "_out_empty"}, 32'(out_empty), 32'd1);
    endtask

    // ch0: a0,a1,EE5  ch1: b0,EE5  ch2: EE(tag2)  ch3: d0,EE5, interleaved.
    task automatic basic_event(input string name, input word_t a0, input word_t a1,
                               input word_t b0, input word_t d0, input word_t ee2,
                               input word_t final_ee);
        exp_q.push_back(a0);
        exp_q.push_back(a1);
        exp_q.push_back(b0);
        exp_q.push_back(d0);
        exp_q.push_back(final_ee);
        start_event(4'b1111);
        put(0, a0);
        put(1, b0);
        put(3, d0);
        put(0, a1);
        put(2, ee2);
        put(3, 23'h600005);
        put(1, 23'h600005);
        put(0, 23'h600005);
        wait_drain(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        data_in = '0;
        ds      = '1;
        chan_en = '0;
        out_re  = 1'b1;
        repeat (2) @(negedge clock);
        chk("rst_out_empty", 32'(out_empty), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_data_out",  32'(data_out),  32'd0);
        chk("rst_hold",      32'(hold),      32'd0);
        chk("rst_overflow",  32'(overflow),  32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        basic_event("basic", 23'h000a00, 23'h000a01, 23'h000b00, 23'h000d00,
                    23'h600005, 23'h600005);
`ifdef WEDGE_MERGE_ISPY_EN
        chk("spy_dv_pulses", 32'(spy_dv_cnt), 32'd5);
        chk("spy_boundary",  32'(spy_bnd_cnt), 32'd4);
`endif

        basic_event("mismatch", 23'h001a00, 23'h001a01, 23'h001b00, 23'h001d00,
                    23'h600006, 23'h700005);

        // Only ch0/ch2 enabled; ch1/ch3 contents must survive for the next event.
        exp_q.push_back(23'h000201);
        exp_q.push_back(23'h000203);
        exp_q.push_back(23'h600005);
        start_event(4'b0101);
        put(1, 23'h000301);
        put(0, 23'h000201);
        put(3, 23'h000303);
        put(2, 23'h000203);
        put(1, 23'h600005);
        put(0, 23'h600005);
        put(3, 23'h600005);
        put(2, 23'h600005);
        wait_drain("en_0101");

        exp_q.push_back(23'h000301);
        exp_q.push_back(23'h000303);
        exp_q.push_back(23'h600005);
        start_event(4'b1111);
        put(0, 23'h600005);
        put(2, 23'h600005);
        wait_drain("retained");

        // Back-pressure: merger idle (chan_en=0), so ch0 only fills.
        out_re = 1'b0;
        for (int k = 1; k <= 65; k++) begin
            put(0, word_t'(32'h1000 + k));
            if (k == 55) chk("hold_at_55",     32'(hold),     32'd0);
            if (k == 56) chk("hold_at_56",     32'(hold),     32'd1);
            if (k == 64) chk("overflow_at_64", 32'(overflow), 32'd0);
            if (k == 65) chk("overflow_at_65", 32'(overflow), 32'd1);
        end

        // Reset while XFER streams the back-pressure words into the output FIFO.
        start_event(4'b1111);
        repeat (20) @(negedge clock);
        chk("pre_reset_out_empty", 32'(out_empty), 32'd0);
        reset = 1'b0;
        @(posedge clock);
        #1;
        chk("mid_rst_out_empty", 32'(out_empty), 32'd1);
        chk("mid_rst_hold",      32'(hold),      32'd0);
        chk("mid_rst_overflow",  32'(overflow),  32'd0);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        @(negedge clock);
        reset  = 1'b1;
        out_re = 1'b1;
        repeat (2) @(negedge clock);

        basic_event("post_reset", 23'h002a00, 23'h002a01, 23'h002b00, 23'h002d00,
                    23'h600005, 23'h600005);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
